spike_injector: RTL and testbench

Host-to-mesh spike ingress stage. It accepts external spike events (destination node, neuron id, payload) over a valid/ready port, buffers them in a small FIFO, and serialises each event into a two-flit packet (header + tail) for the local input port of the mesh's edge router at node (0,0). Events addressed outside the mesh or neuron range are discarded and flagged.

---
 rtl/spike_injector.sv | 141 ++++++++++++++
 tb/tb_spike_injector.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_injector.sv
// Host-to-mesh spike ingress: range-checks events, buffers them and emits header+tail flits.
// Optional statistics counters (pkt_count, drop_count) are enabled by defining INJECTOR_STATS_EN.
module spike_injector #(
    parameter int unsigned ROWS        = 3,
    parameter int unsigned COLS        = 3,
    parameter int unsigned NUM_NEURONS = 4,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_row,
    input  logic [7:0]            in_col,
    input  logic [7:0]            in_neuron,
    input  logic [29:0]           in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_flit,
    output logic                  drop_err
`ifdef INJECTOR_STATS_EN
    ,
    output logic [15:0]           pkt_count,
    output logic [15:0]           drop_count
`endif
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]   CntFull = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0]   CntOne  = (PW+1)'(1);
    localparam logic [PW-1:0] PtrOne  = PW'(1);
    localparam logic [8:0]    RowLim  = 9'(ROWS);
    localparam logic [8:0]    ColLim  = 9'(COLS);
    localparam logic [8:0]    NeuLim  = 9'(NUM_NEURONS);

    typedef enum logic [1:0] {StIdle, StHead, StTail} state_e;

    state_e        state_q, state_d;
    logic [53:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q, count_d;
    logic          drop_err_q;
    logic          accept, in_range, push, drop, pop;
    logic [53:0]   head;

    assign in_ready = (count_q != CntFull);
    assign accept   = in_valid && in_ready;
    assign in_range = ({1'b0, in_row} < RowLim) && ({1'b0, in_col} < ColLim) &&
                      ({1'b0, in_neuron} < NeuLim);
    assign push     = accept && in_range;
    assign drop     = accept && !in_range;
    assign pop      = (state_q == StTail) && out_ready;
    assign head     = mem_q[rd_ptr_q];
    assign drop_err = drop_err_q;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_row, in_col, in_neuron, in_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_err_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
            count_q    <= count_d;
            drop_err_q <= drop;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // FSM: next state; after a pop, continue straight to the next header if anything remains
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (count_q != '0) state_d = StHead;
            StHead:  if (out_ready) state_d = StTail;
            StTail:  if (out_ready) state_d = (count_d != '0) ? StHead : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs; the head entry cannot change until its tail is popped, so flits stay stable
    always_comb begin
        out_valid = 1'b0;
        out_flit  = '0;
        unique case (state_q)
            StHead: begin
                out_valid = 1'b1;
                out_flit  = {2'b10, 6'b0, head[53:30]};
            end
            StTail: begin
                out_valid = 1'b1;
                out_flit  = {2'b01, head[29:0]};
            end
            default: begin
                out_valid = 1'b0;
                out_flit  = '0;
            end
        endcase
    end

`ifdef INJECTOR_STATS_EN
    logic [15:0] pkt_count_q, drop_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            if (pop)  pkt_count_q  <= pkt_count_q + 16'd1;
            if (drop) drop_count_q <= drop_count_q + 16'd1;
        end
    end

    assign pkt_count  = pkt_count_q;
    assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_spike_injector.sv
// Self-checking bench for spike_injector: flit scoreboard, vector table and multi-cycle corners.
// Counter checks are compiled in when INJECTOR_STATS_EN is defined.
module tb_spike_injector;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [7:0]  in_row, in_col, in_neuron;
    logic [29:0] in_data;
    logic        out_valid, out_ready;
    logic [31:0] out_flit;
    logic        drop_err;
    logic [15:0] pkt_count, drop_count;

    int checks = 0;
    int errors = 0;
    int exp_pkts = 0;
    int exp_drops = 0;
    logic [31:0] sb_q [$];

    typedef struct {
        logic [7:0]  row;
        logic [7:0]  col;
        logic [7:0]  neuron;
        logic [29:0] data;
        logic        drop;
    } vec_t;
    vec_t vecs [8];

    spike_injector dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .in_col    (in_col),
        .in_neuron (in_neuron),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_flit  (out_flit),
        .drop_err  (drop_err)
`ifdef INJECTOR_STATS_EN
        ,
        .pkt_count (pkt_count),
        .drop_count(drop_count)
`endif
    );

`ifndef INJECTOR_STATS_EN
    assign pkt_count  = '0;
    assign drop_count = '0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] hdr(input logic [7:0] r, input logic [7:0] c,
                                        input logic [7:0] n);
        return {2'b10, 6'b0, r, c, n};
    endfunction

    function automatic logic [31:0] tl(input logic [29:0] d);
        return {2'b01, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one event and hold it until accepted; record what the DUT should do with it.
    task automatic send(input logic [7:0] r, input logic [7:0] c, input logic [7:0] n,
                        input logic [29:0] d);
        int k = 0;
        in_valid = 1'b1; in_row = r; in_col = c; in_neuron = n; in_data = d;
        while (!in_ready && k < 200) begin
            tick();
            k++;
        end
        if (!in_ready) check("send_timeout", {31'b0, in_ready}, 32'd1);
        if (r < 3 && c < 3 && n < 4) begin
            sb_q.push_back(hdr(r, c, n));
            sb_q.push_back(tl(d));
            exp_pkts++;
        end else begin
            exp_drops++;
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb_q.size() != 0 && k < 300) begin
            tick();
            k++;
        end
        check("drain_empty", sb_q.size(), 0);
        tick();
        tick();
        check("idle_after_drain", {31'b0, out_valid}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        sb_q.delete();
        exp_pkts = 0;
        exp_drops = 0;
    endtask

    task automatic check_counts(input string tag);
`ifdef INJECTOR_STATS_EN
        check({tag, "_pkt_count"}, {16'b0, pkt_count}, exp_pkts);
        check({tag, "_drop_count"}, {16'b0, drop_count}, exp_drops);
`endif
    endtask

    // Scoreboard: every flit handed over at the coming edge must match the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_flit: got %h expected none", out_flit);
            end else begin
                check("flit", out_flit, sb_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'd0,   8'd0,   8'd0,   30'h0000001, 1'b0};
        vecs[1] = '{8'd2,   8'd2,   8'd3,   30'h3FFFFFFF, 1'b0};
        vecs[2] = '{8'd3,   8'd0,   8'd0,   30'h0000002, 1'b1};
        vecs[3] = '{8'd0,   8'd3,   8'd0,   30'h0000003, 1'b1};
        vecs[4] = '{8'd0,   8'd0,   8'd4,   30'h0000004, 1'b1};
        vecs[5] = '{8'd1,   8'd1,   8'd1,   30'h2AAAAAAA, 1'b0};
        vecs[6] = '{8'd255, 8'd255, 8'd255, 30'h0000005, 1'b1};
        vecs[7] = '{8'd2,   8'd1,   8'd0,   30'h1555555, 1'b0};

        in_valid = 1'b0; in_row = '0; in_col = '0; in_neuron = '0; in_data = '0;
        out_ready = 1'b0;
        rst = 1'b1;
        #2;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_flit", out_flit, 32'd0);
        check("rst_drop_err", {31'b0, drop_err}, 32'd0);
        check_counts("rst");
        tick();
        rst = 1'b0;

        // Single event: exact latency with out_ready high
        out_ready = 1'b1;
        send(8'd1, 8'd2, 8'd3, 30'h0000ABC);
        check("lat_e0_valid", {31'b0, out_valid}, 32'd0);
        tick();
        check("lat_e1_valid", {31'b0, out_valid}, 32'd1);
        check("lat_e1_flit", out_flit, 32'h80010203);
        tick();
        check("lat_e2_valid", {31'b0, out_valid}, 32'd1);
        check("lat_e2_flit", out_flit, 32'h40000ABC);
        tick();
        check("lat_e3_idle", {31'b0, out_valid}, 32'd0);
        check_counts("single");

        // Backpressure in HEAD: flit held stable
        out_ready = 1'b0;
        send(8'd1, 8'd2, 8'd3, 30'h0000ABC);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_flit", out_flit, 32'h80010203);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("hold_tail", out_flit, 32'h40000ABC);
        drain();

        // Fill the FIFO, refuse a fifth event, then drain in order
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'(i % 3), 8'd1, 8'(i), 30'(32'h100 + i));
        check("full_in_ready", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b1; in_row = 8'd0; in_col = 8'd0; in_neuron = 8'd0; in_data = 30'h3;
        tick();
        tick();
        check("full_still_blocked", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("full_before_pop", {31'b0, in_ready}, 32'd0);
        tick();
        check("ready_after_pop", {31'b0, in_ready}, 32'd1);
        drain();
        check_counts("fill");

        // Vector table: in-range and out-of-range events, drops back to back
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].row, vecs[i].col, vecs[i].neuron, vecs[i].data);
            check($sformatf("vec%0d_drop_err", i), {31'b0, drop_err}, {31'b0, vecs[i].drop});
            if (vecs[i].drop) check($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, 32'd1);
        end
        tick();
        check("drop_err_clear", {31'b0, drop_err}, 32'd0);
        drain();
        check_counts("table");

        // Reset while sending a tail with two more entries queued
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(8'd2, 8'd2, 8'(i), 30'(32'h200 + i));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pre_rst_tail", out_flit, 32'h40000200);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("mid_rst_out_flit", out_flit, 32'd0);
        sb_q.delete();
        exp_pkts = 0;
        exp_drops = 0;
        check_counts("mid_rst");
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("post_rst_empty", {31'b0, out_valid}, 32'd0);
        send(8'd0, 8'd1, 8'd2, 30'h0ABCDEF);
        drain();
        check_counts("post_rst");

        // Continuous stream: push and pop overlap while the FIFO is nearly full
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) send(8'(i % 3), 8'((i + 1) % 3), 8'(i % 4), 30'(32'h1000 + i));
        drain();
        check_counts("stream");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
